// File: rtl/leer_crono.sv
// leer_crono: walks the chronometer register window and commits seg/min/hora atomically.
// Optional BCD validation of each sampled byte: define CRONO_BCD_CHECK_EN.
module leer_crono #(
  parameter logic [7:0] FIRST_ADDR = 8'h01,
  parameter int         NUM_REGS   = 3,
  parameter int         SETUP_CYC  = 4,
  parameter int         RD_CYC     = 256,
  parameter int         HOLD_CYC   = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic [7:0] data_in,
  output logic [7:0] dir_out,
  output logic       RD,
  output logic       WR,
  output logic       busy,
  output logic       ready,
  output logic       err,
  output logic [7:0] seg,
  output logic [7:0] min,
  output logic [7:0] hora
);

  typedef enum logic [2:0] {
    IDLE,
    ADDR,
    STROBE,
    HOLD,
    NEXT,
    DONE
  } state_t;

  localparam logic [8:0] S_END = 9'(SETUP_CYC - 1);
  localparam logic [8:0] R_END = 9'(RD_CYC - 1);
  localparam logic [8:0] H_END = 9'(HOLD_CYC - 1);
  localparam logic [1:0] LAST  = 2'(NUM_REGS - 1);

  state_t     state;
  logic [8:0] cnt;
  logic [1:0] idx;
  logic       start_q;
  logic [7:0] shadow [NUM_REGS];
  logic [7:0] cur_addr;

  assign cur_addr = FIRST_ADDR + 8'(idx);
  assign WR       = 1'b0;

`ifdef CRONO_BCD_CHECK_EN
  logic seq_err;

  function automatic logic bcd_bad(input logic [7:0] b);
    return (b[7:4] > 4'd9) || (b[3:0] > 4'd9);
  endfunction
`else
  assign err = 1'b0;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= IDLE;
      cnt     <= '0;
      idx     <= '0;
      start_q <= 1'b0;
      for (int i = 0; i < NUM_REGS; i++)
        shadow[i] <= '0;
      dir_out <= '0;
      RD      <= 1'b0;
      busy    <= 1'b0;
      ready   <= 1'b0;
      seg     <= '0;
      min     <= '0;
      hora    <= '0;
`ifdef CRONO_BCD_CHECK_EN
      seq_err <= 1'b0;
      err     <= 1'b0;
`endif
    end else begin
      start_q <= start;
      ready   <= 1'b0;
      unique case (state)
        IDLE: begin
          if (start && !start_q) begin
            state   <= ADDR;
            cnt     <= '0;
            idx     <= '0;
            busy    <= 1'b1;
            dir_out <= FIRST_ADDR;
`ifdef CRONO_BCD_CHECK_EN
            seq_err <= 1'b0;
`endif
          end
        end
        ADDR: begin
          if (cnt == S_END) begin
            state <= STROBE;
            cnt   <= '0;
            RD    <= 1'b1;
          end else begin
            cnt <= cnt + 9'd1;
          end
        end
        STROBE: begin
          if (cnt == R_END) begin
            state       <= HOLD;
            cnt         <= '0;
            RD          <= 1'b0;
            shadow[idx] <= data_in;
`ifdef CRONO_BCD_CHECK_EN
            if (bcd_bad(data_in))
              seq_err <= 1'b1;
`endif
          end else begin
            cnt <= cnt + 9'd1;
          end
        end
        HOLD: begin
          if (cnt == H_END) begin
            state <= NEXT;
            cnt   <= '0;
          end else begin
            cnt <= cnt + 9'd1;
          end
        end
        NEXT: begin
          cnt <= '0;
          if (idx == LAST) begin
            state   <= DONE;
            idx     <= '0;
            dir_out <= '0;
            ready   <= 1'b1;
`ifdef CRONO_BCD_CHECK_EN
            err <= err | seq_err;
            if (!seq_err) begin
              seg  <= shadow[0];
              min  <= shadow[1];
              hora <= shadow[2];
            end
`else
            seg  <= shadow[0];
            min  <= shadow[1];
            hora <= shadow[2];
`endif
          end else begin
            state   <= ADDR;
            idx     <= idx + 2'd1;
            dir_out <= cur_addr + 8'd1;
          end
        end
        DONE: begin
          state <= IDLE;
          cnt   <= '0;
          busy  <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_leer_crono.sv
// tb_leer_crono: checks leer_crono cycle by cycle against a timeline model.
// Two instances: default parameters and a short S=R=H=1, FIRST_ADDR=FE build.
module tb_leer_crono;

  localparam int N = 3;

  logic clk = 1'b0;
  logic reset;
  logic start;
  logic sel;
  logic [7:0] mem [256];

  logic       start_a, rd_a, wr_a, busy_a, ready_a, err_a;
  logic [7:0] din_a, dir_a, seg_a, min_a, hora_a;
  logic       start_b, rd_b, wr_b, busy_b, ready_b, err_b;
  logic [7:0] din_b, dir_b, seg_b, min_b, hora_b;

  logic       m_rd, m_wr, m_busy, m_ready, m_err;
  logic [7:0] m_dir, m_seg, m_min, m_hora;

  logic [7:0] e_seg [2];
  logic [7:0] e_min [2];
  logic [7:0] e_hora [2];
  logic       e_err [2];

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  assign start_a = sel ? 1'b0 : start;
  assign start_b = sel ? start : 1'b0;
  assign din_a   = mem[dir_a];
  assign din_b   = mem[dir_b];

  leer_crono dut_a (
    .clk(clk), .reset(reset), .start(start_a),
    .data_in(din_a), .dir_out(dir_a),
    .RD(rd_a), .WR(wr_a), .busy(busy_a),
    .ready(ready_a), .err(err_a),
    .seg(seg_a), .min(min_a), .hora(hora_a)
  );

  leer_crono #(
    .FIRST_ADDR(8'hFE), .NUM_REGS(3),
    .SETUP_CYC(1), .RD_CYC(1), .HOLD_CYC(1)
  ) dut_b (
    .clk(clk), .reset(reset), .start(start_b),
    .data_in(din_b), .dir_out(dir_b),
    .RD(rd_b), .WR(wr_b), .busy(busy_b),
    .ready(ready_b), .err(err_b),
    .seg(seg_b), .min(min_b), .hora(hora_b)
  );

  always_comb begin
    m_rd    = sel ? rd_b    : rd_a;
    m_wr    = sel ? wr_b    : wr_a;
    m_busy  = sel ? busy_b  : busy_a;
    m_ready = sel ? ready_b : ready_a;
    m_err   = sel ? err_b   : err_a;
    m_dir   = sel ? dir_b   : dir_a;
    m_seg   = sel ? seg_b   : seg_a;
    m_min   = sel ? min_b   : min_a;
    m_hora  = sel ? hora_b  : hora_a;
  end

  function automatic logic bcd_bad(input logic [7:0] b);
    return (b[7:4] > 4'd9) || (b[3:0] > 4'd9);
  endfunction

  function automatic logic [7:0] rnd_bcd();
    logic [3:0] hi, lo;
    hi = 4'($urandom_range(0, 9));
    lo = 4'($urandom_range(0, 9));
    return {hi, lo};
  endfunction

  task automatic clear_model();
    for (int i = 0; i < 2; i++) begin
      e_seg[i]  = 8'h00;
      e_min[i]  = 8'h00;
      e_hora[i] = 8'h00;
      e_err[i]  = 1'b0;
    end
  endtask

  task automatic kick();
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    start = 1'b1;
  endtask

  // t counts edges after the start-detect edge E0; every output is a
  // function of t via period arithmetic.
  task automatic watch(input int pulse_t, input int rst_t, input int extra);
    int s, r, h, p, d, si, k, ph;
    logic [7:0] first, a1, a2, ns, nm, nh;
    logic [7:0] xd, xs, xm, xh;
    logic       nbad, xrd, xb, xr, xe;
    si    = sel ? 1 : 0;
    s     = sel ? 1 : 4;
    r     = sel ? 1 : 256;
    h     = sel ? 1 : 4;
    first = sel ? 8'hFE : 8'h01;
    a1    = first + 8'd1;
    a2    = first + 8'd2;
    p     = s + r + h + 1;
    d     = N * p;
    ns    = mem[first];
    nm    = mem[a1];
    nh    = mem[a2];
    nbad  = 1'b0;
`ifdef CRONO_BCD_CHECK_EN
    nbad = bcd_bad(ns) | bcd_bad(nm) | bcd_bad(nh);
`endif
    for (int t = 0; t <= d + 1 + extra; t++) begin
      @(posedge clk);
      #1;
      if (t == rst_t) begin
        reset = 1'b1;
        #1;
        checks++;
        if ({m_rd, m_busy, m_ready, m_err, m_dir,
             m_seg, m_min, m_hora} !== '0) begin
          errors++;
          $display("FAIL rst_mid t=%0d rd=%b busy=%b rdy=%b err=%b dir=%h val=%h%h%h want all 0",
                   t, m_rd, m_busy, m_ready, m_err,
                   m_dir, m_seg, m_min, m_hora);
        end
        clear_model();
        return;
      end
      k   = t / p;
      ph  = t % p;
      xb  = (t <= d);
      xr  = (t == d);
      xd  = (t < d) ? first + 8'(k) : 8'h00;
      xrd = (t < d) && (ph >= s) && (ph < s + r);
      if (t < d || nbad) begin
        xs = e_seg[si];
        xm = e_min[si];
        xh = e_hora[si];
      end else begin
        xs = ns;
        xm = nm;
        xh = nh;
      end
      xe = (t < d) ? e_err[si] : (e_err[si] | nbad);
      checks++;
      if (m_rd !== xrd) begin
        errors++;
        $display("FAIL rd t=%0d got %b want %b", t, m_rd, xrd);
      end
      checks++;
      if (m_dir !== xd) begin
        errors++;
        $display("FAIL dir t=%0d got %h want %h", t, m_dir, xd);
      end
      checks++;
      if (m_busy !== xb) begin
        errors++;
        $display("FAIL busy t=%0d got %b want %b", t, m_busy, xb);
      end
      checks++;
      if (m_ready !== xr) begin
        errors++;
        $display("FAIL ready t=%0d got %b want %b", t, m_ready, xr);
      end
      checks++;
      if (m_wr !== 1'b0) begin
        errors++;
        $display("FAIL wr t=%0d got %b want 0", t, m_wr);
      end
      checks++;
      if ({m_seg, m_min, m_hora} !== {xs, xm, xh}) begin
        errors++;
        $display("FAIL values t=%0d got %h/%h/%h want %h/%h/%h",
                 t, m_seg, m_min, m_hora, xs, xm, xh);
      end
      checks++;
      if (m_err !== xe) begin
        errors++;
        $display("FAIL err t=%0d got %b want %b", t, m_err, xe);
      end
      @(negedge clk);
      if (t == pulse_t)
        start = 1'b0;
      if (t == pulse_t + 1)
        start = 1'b1;
    end
    if (!nbad) begin
      e_seg[si]  = ns;
      e_min[si]  = nm;
      e_hora[si] = nh;
    end
    e_err[si] = e_err[si] | nbad;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    start = 1'b0;
    sel   = 1'b0;
    clear_model();
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if ({rd_a, busy_a, ready_a, err_a, dir_a, seg_a, min_a, hora_a,
         rd_b, busy_b, ready_b, err_b, dir_b, seg_b, min_b, hora_b} !== '0) begin
      errors++;
      $display("FAIL reset_hold a=%b%b%b%b %h %h%h%h b=%b%b%b%b %h %h%h%h want 0",
               rd_a, busy_a, ready_a, err_a, dir_a, seg_a, min_a, hora_a,
               rd_b, busy_b, ready_b, err_b, dir_b, seg_b, min_b, hora_b);
    end
    @(negedge clk);
    reset = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if ({rd_a, busy_a, ready_a, wr_a, dir_a, rd_b, busy_b, wr_b, dir_b} !== '0) begin
      errors++;
      $display("FAIL reset_idle a=%b%b%b%b %h b=%b%b%b %h want 0",
               rd_a, busy_a, ready_a, wr_a, dir_a, rd_b, busy_b, wr_b, dir_b);
    end
  endtask

  task automatic test_basic();
    mem[1] = 8'h45;
    mem[2] = 8'h30;
    mem[3] = 8'h12;
    kick();
    watch(-1, -1, 3);
    checks++;
    if ({seg_a, min_a, hora_a} !== 24'h453012) begin
      errors++;
      $display("FAIL basic_commit got %h%h%h want 453012", seg_a, min_a, hora_a);
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 3; i++) begin
      for (int a = 1; a <= 3; a++)
        mem[a] = rnd_bcd();
      kick();
      watch(-1, -1, 2);
    end
  endtask

  task automatic test_hold_start();
    mem[1] = rnd_bcd();
    kick();
    watch(-1, -1, 800);
    mem[2] = rnd_bcd();
    kick();
    watch(100, -1, 20);
  endtask

  task automatic test_done_start();
    mem[3] = rnd_bcd();
    kick();
    watch(794, -1, 20);
  endtask

  task automatic test_reset_mid();
    kick();
    watch(-1, 300, 0);
    @(negedge clk);
    reset = 1'b0;
    start = 1'b0;
    mem[1] = rnd_bcd();
    kick();
    watch(-1, -1, 2);
  endtask

  task automatic test_bcd();
    mem[1] = rnd_bcd();
    mem[2] = 8'h3A;
    mem[3] = rnd_bcd();
    kick();
    watch(-1, -1, 2);
    checks++;
`ifdef CRONO_BCD_CHECK_EN
    if (err_a !== 1'b1) begin
      errors++;
      $display("FAIL bcd_err got %b want 1", err_a);
    end
`else
    if (min_a !== 8'h3A || err_a !== 1'b0) begin
      errors++;
      $display("FAIL bcd_nocheck min=%h err=%b want 3a 0", min_a, err_a);
    end
`endif
    mem[2] = rnd_bcd();
    kick();
    watch(-1, -1, 2);
  endtask

  task automatic test_small();
    @(negedge clk);
    start = 1'b0;
    sel   = 1'b1;
    for (int i = 0; i < 2; i++) begin
      mem[8'hFE] = rnd_bcd();
      mem[8'hFF] = rnd_bcd();
      mem[8'h00] = rnd_bcd();
      kick();
      watch(-1, -1, 4);
    end
  endtask

  initial begin
    for (int i = 0; i < 256; i++)
      mem[i] = rnd_bcd();
    test_reset();
    test_basic();
    test_random();
    test_hold_start();
    test_done_start();
    test_reset_mid();
    test_bcd();
    test_small();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
